frame_buffer_ctrl: RTL and testbench
====================================

Name: frame_buffer_ctrl

Overview:
- Controller that captures one frame from a valid/ready input stream into an external single-port RAM, then replays that frame on a valid/ready output stream.
- Sits directly upstream of the team's single-port RAM and drives its we/addr/din.
- RAM read is asynchronous (dout is combinational from addr), so replay adds zero read latency.
- Fill and drain are serialised: the RAM has one address port, so the two phases never overlap.

Parameters:
- addr_width, 7, RAM address width; depth = 2**addr_width words.
- data_width, 10, data word width.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin a fill+drain sequence; sampled only in IDLE.
- frame_len  in  addr_width+1  words per frame; sampled with start.
- s_valid  in  1  input word valid.
- s_ready  out  1  controller accepts the input word.
- s_data  in  data_width  input word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the output word.
- m_data  out  data_width  output word.
- m_last  out  1  marks the final word of the frame.
- busy  out  1  high in FILL or DRAIN.
- done  out  1  one-cycle pulse after the last output handshake.
- ram_we  out  1  RAM write enable.
- ram_addr  out  addr_width  RAM address.
- ram_din  out  data_width  RAM write data.
- ram_dout  in  data_width  RAM asynchronous read data.

Behaviour:
- **Reset.** On reset=1 at posedge: state=IDLE, cnt=0, len_q=0, done=0.
  - Outputs during and after reset: s_ready=0, m_valid=0, m_last=0, ram_we=0, ram_addr=0, busy=0.
  - RAM contents are not cleared.
- **Reset mid-operation.** Aborts the fill or drain immediately. No done pulse. Partial frame is discarded.
- **Registered state:** state, cnt (addr_width+1 bits), len_q (addr_width+1 bits), done.
- **Combinational outputs:** s_ready, m_valid, m_last, ram_we, ram_addr, ram_din, m_data, busy.
- **IDLE.**
  - s_ready=0, m_valid=0, ram_we=0, ram_addr=0.
  - start=1 with frame_len!=0: go to FILL, cnt<=0, len_q<=min(frame_len, 2**addr_width).
  - start=1 with frame_len=0: ignored; stay in IDLE, no done pulse.
- **FILL.**
  - s_ready=1, ram_addr=cnt[addr_width-1:0], ram_din=s_data, ram_we=s_valid.
  - On s_valid: cnt<=cnt+1.
  - If cnt==len_q-1 on that handshake: go to DRAIN and cnt<=0.
  - s_valid=0 holds state; no write occurs.
- **DRAIN.**
  - m_valid=1, ram_addr=cnt[addr_width-1:0], m_data=ram_dout, m_last=(cnt==len_q-1), ram_we=0, s_ready=0.
  - On m_ready: cnt<=cnt+1.
  - On the m_last handshake: go to IDLE, cnt<=0, done<=1 for exactly one cycle.
  - m_ready=0 holds m_data and m_last stable.
- **start** is ignored while busy=1.
- **Back-to-back frames.** start asserted in the cycle done=1 (state already IDLE) is accepted, so the earliest next FILL begins 2 cycles after the last drain handshake.
- **Throughput.** One word per cycle in each phase. A frame of N words takes N fill cycles plus N drain cycles minimum.
- **Wrap.** cnt never exceeds len_q-1 while active. len_q=2**addr_width writes every address once.

Optional Feature:
- Macro: FRAME_BUF_REVERSE_DRAIN_EN.
- **Defined:** DRAIN drives ram_addr=len_q-1-cnt, so the frame is replayed last-in-first-out. m_last still flags the final output word (address 0).
- **Undefined:** first-in-first-out replay as described above.
- FILL behaviour and all handshakes are identical in both builds.

Decomposition:
- Shared package frame_buf_pkg holds:
  - typedef enum logic [1:0] state_t {ST_IDLE, ST_FILL, ST_DRAIN}.
  - Default width constants FB_ADDR_WIDTH=7 and FB_DATA_WIDTH=10.
- No sub-module: counter, length clamp and FSM are inline.
- The RAM is instantiated alongside this block in the enclosing wrapper, not inside it.

Test Plan:
- **Basic FIFO replay.** reset, then start with frame_len=4, push 10,20,30,40 with s_valid held high, m_ready=1.
  - Expect RAM writes at addresses 0..3.
  - Expect m_data 10,20,30,40 on 4 consecutive cycles, m_last only on 40.
  - Expect done=1 one cycle after the last handshake.
- **Backpressure and gaps.** frame_len=3, s_valid toggled 1,0,1,0,1, then m_ready pattern 0,1,0,1,1.
  - Expect no writes in s_valid=0 cycles.
  - Expect m_data stable while m_ready=0.
  - Expect output order preserved.
- **Boundaries.**
  - frame_len=0 with start: stays IDLE, busy=0, no done.
  - frame_len=200 with addr_width=7: clamped to 128; addresses 0..127 written, m_last at word 128.
  - frame_len=1: single word, m_last on first output.
- **Ignored start and back-to-back.**
  - start pulsed during FILL: no effect on cnt or len_q.
  - start asserted in the done cycle: accepted, FILL begins the next cycle.
- **Reset mid-DRAIN.** reset after 2 of 4 outputs.
  - Next cycle: IDLE, m_valid=0, busy=0, no done pulse.
  - A new 2-word frame then replays correctly.
- **Reverse build.** With FRAME_BUF_REVERSE_DRAIN_EN defined, frame 1,2,3,4.
  - Expect m_data 4,3,2,1 with m_last on 1.

Source files
------------

// File: rtl/frame_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : frame_buf_pkg                                                 |
// | Purpose  : Shared types and default widths for the frame buffer          |
// |            controller.                                                   |
// | Contents : state_t        - controller phase encoding                    |
// |            FB_ADDR_WIDTH  - default RAM address width                    |
// |            FB_DATA_WIDTH  - default data word width                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package frame_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FB_ADDR_WIDTH = 7;
  localparam int FB_DATA_WIDTH = 10;

endpackage
`default_nettype wire

// File: rtl/frame_buffer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : frame_buffer_ctrl                                             |
// | Purpose  : Captures one frame from a valid/ready stream into an external |
// |            single-port RAM (async read), then replays it on a            |
// |            valid/ready output stream. Fill and drain never overlap.      |
// | Ports    : clk_i, reset_i       - clock, sync active-high reset          |
// |            start_i, frame_len_i - begin a sequence of frame_len words    |
// |            s_valid_i/s_ready_o/s_data_i            - input stream        |
// |            m_valid_o/m_ready_i/m_data_o/m_last_o   - output stream       |
// |            busy_o, done_o       - activity flag, end-of-frame pulse      |
// |            ram_we_o/ram_addr_o/ram_din_o/ram_dout_i - RAM interface      |
// | Options  : FRAME_BUF_REVERSE_DRAIN_EN - replay frame last-in-first-out   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module frame_buffer_ctrl
  import frame_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   frame_len_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);

  localparam int                 c_CNT_W = ADDR_WIDTH + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [c_CNT_W-1:0] c_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [c_CNT_W-1:0] len_q, len_d;
  logic               done_q, done_d;

  logic [c_CNT_W-1:0]    w_len_m1;
  logic [c_CNT_W-1:0]    w_len_clamp;
  logic                  w_at_last;
  logic [ADDR_WIDTH-1:0] w_drain_addr;

  assign w_len_m1    = len_q - c_ONE;
  assign w_at_last   = (cnt_q == w_len_m1);
  // Frames longer than the RAM are truncated to one full pass of the RAM.
  assign w_len_clamp = (frame_len_i > c_DEPTH) ? c_DEPTH : frame_len_i;

`ifdef FRAME_BUF_REVERSE_DRAIN_EN
  // Modulo-2**ADDR_WIDTH subtraction: the low bits of (len-1-cnt) are exact
  // because cnt never exceeds len-1 while draining.
  assign w_drain_addr = w_len_m1[ADDR_WIDTH-1:0] - cnt_q[ADDR_WIDTH-1:0];
`else
  assign w_drain_addr = cnt_q[ADDR_WIDTH-1:0];
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (frame_len_i != '0)) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          len_d   = w_len_clamp;
        end
      end
      ST_FILL: begin
        if (s_valid_i) begin
          if (w_at_last) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_ONE;
          end
        end
      end
      ST_DRAIN: begin
        if (m_ready_i) begin
          if (w_at_last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + c_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic; reset forces every handshake and RAM strobe low even before
  // the state register has been cleared.
  always_comb begin
    s_ready_o  = 1'b0;
    m_valid_o  = 1'b0;
    m_last_o   = 1'b0;
    m_data_o   = '0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_din_o  = s_data_i;
    busy_o     = 1'b0;
    done_o     = done_q;
    if (!reset_i) begin
      case (state_q)
        ST_FILL: begin
          busy_o     = 1'b1;
          s_ready_o  = 1'b1;
          ram_we_o   = s_valid_i;
          ram_addr_o = cnt_q[ADDR_WIDTH-1:0];
        end
        ST_DRAIN: begin
          busy_o     = 1'b1;
          m_valid_o  = 1'b1;
          m_last_o   = w_at_last;
          m_data_o   = ram_dout_i;
          ram_addr_o = w_drain_addr;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_frame_buffer_ctrl                                          |
// | Purpose  : Self-checking bench for frame_buffer_ctrl. A frame-level      |
// |            model (queue of captured words) predicts every output each    |
// |            cycle; directed tests also pin literal expected sequences.    |
// | Options  : FRAME_BUF_REVERSE_DRAIN_EN - expect last-in-first-out replay  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_frame_buffer_ctrl;

  localparam int AW    = 7;
  localparam int DW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef FRAME_BUF_REVERSE_DRAIN_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW:0]   frame_len;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  frame_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .frame_len_i(frame_len),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_data_i   (s_data),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .m_last_o   (m_last),
    .busy_o     (busy),
    .done_o     (done),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  // External single-port RAM with asynchronous read.
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;
  assign ram_dout = ram[ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  // phase: 0 idle, 1 capturing, 2 replaying
  int m_phase = 0;
  int m_len   = 0;
  int m_idx   = 0;
  bit m_done  = 1'b0;
  int frame[$];

  // observation logs for literal checks
  int out_q[$];
  int last_q[$];
  int wr_q[$];
  int cyc      = 0;
  int last_cyc = -1;
  int done_cyc = -1;

  task automatic model_step();
    bit e_busy, e_srdy, e_mval, e_last, e_we;
    int e_addr, e_din, e_data, pos;
    bit nxt_done;
    e_busy = 0; e_srdy = 0; e_mval = 0; e_last = 0; e_we = 0;
    e_addr = 0; e_din = 0; e_data = 0;
    if (!reset) begin
      if (m_phase == 1) begin
        e_busy = 1; e_srdy = 1; e_we = s_valid;
        e_addr = frame.size(); e_din = int'(s_data);
      end else if (m_phase == 2) begin
        pos    = REV ? (m_len - 1 - m_idx) : m_idx;
        e_busy = 1; e_mval = 1; e_addr = pos; e_data = frame[pos];
        e_last = (m_idx == m_len - 1);
      end
    end
    chk("busy",     32'(busy),     32'(e_busy));
    chk("s_ready",  32'(s_ready),  32'(e_srdy));
    chk("m_valid",  32'(m_valid),  32'(e_mval));
    chk("m_last",   32'(m_last),   32'(e_last));
    chk("ram_we",   32'(ram_we),   32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("done",     32'(done),     32'(m_done));
    if (e_we)   chk("ram_din", 32'(ram_din), 32'(e_din));
    if (e_mval) chk("m_data",  32'(m_data),  32'(e_data));

    if (m_valid && m_ready) begin
      out_q.push_back(int'(m_data));
      last_q.push_back(int'(m_last));
      if (m_last) last_cyc = cyc;
    end
    if (ram_we) wr_q.push_back(int'(ram_addr));
    if (done) done_cyc = cyc;
    cyc++;

    // advance to the state after the coming clock edge
    nxt_done = 0;
    if (reset) begin
      m_phase = 0;
      frame.delete();
    end else if (m_phase == 0) begin
      if (start && frame_len != 0) begin
        m_phase = 1;
        m_len   = (int'(frame_len) > DEPTH) ? DEPTH : int'(frame_len);
        frame.delete();
      end
    end else if (m_phase == 1) begin
      if (s_valid) begin
        frame.push_back(int'(s_data));
        if (frame.size() == m_len) begin
          m_phase = 2;
          m_idx   = 0;
        end
      end
    end else begin
      if (m_ready) begin
        if (m_idx == m_len - 1) begin
          m_phase  = 0;
          nxt_done = 1;
        end else begin
          m_idx++;
        end
      end
    end
    m_done = nxt_done;
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    start = 1'b1; frame_len = (AW+1)'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic push(input int d, input bit v);
    s_valid = v; s_data = DW'(d);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      if (done === 1'b1) seen = 1;
      else tick();
    end
    if (!seen) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic clear_logs();
    out_q.delete(); last_q.delete(); wr_q.delete();
  endtask

  function automatic int outw(input int k);
    return (k < out_q.size()) ? out_q[k] : -1;
  endfunction

  function automatic int lastw(input int k);
    return (k < last_q.size()) ? last_q[k] : -1;
  endfunction

  function automatic int wrw(input int k);
    return (k < wr_q.size()) ? wr_q[k] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int nl;
    reset = 1'b1; start = 1'b0; frame_len = '0; s_valid = 1'b0;
    s_data = '0; m_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_addr", 32'(ram_addr), 32'(0));
    tick();

    // Basic replay
    clear_logs();
    m_ready = 1'b1;
    start_frame(4);
    push(10, 1); push(20, 1); push(30, 1); push(40, 1);
    wait_done(20);
    tick();
    chk("t1_nout", 32'(out_q.size()), 32'(4));
    chk("t1_o0", 32'(outw(0)), REV ? 32'(40) : 32'(10));
    chk("t1_o1", 32'(outw(1)), REV ? 32'(30) : 32'(20));
    chk("t1_o2", 32'(outw(2)), REV ? 32'(20) : 32'(30));
    chk("t1_o3", 32'(outw(3)), REV ? 32'(10) : 32'(40));
    chk("t1_last2", 32'(lastw(2)), 32'(0));
    chk("t1_last3", 32'(lastw(3)), 32'(1));
    chk("t1_wr0", 32'(wrw(0)), 32'(0));
    chk("t1_wr3", 32'(wrw(3)), 32'(3));
    chk("t1_done_lat", 32'(done_cyc - last_cyc), 32'(1));

    // Gaps on input, backpressure on output
    clear_logs();
    m_ready = 1'b0;
    start_frame(3);
    push(5, 1); push(999, 0); push(6, 1); push(998, 0); push(7, 1);
    m_ready = 1'b0; tick();
    m_ready = 1'b1; tick();
    m_ready = 1'b0; tick();
    m_ready = 1'b1; tick();
    wait_done(10);
    tick();
    chk("t2_nwr", 32'(wr_q.size()), 32'(3));
    chk("t2_wr2", 32'(wrw(2)), 32'(2));
    chk("t2_o0", 32'(outw(0)), REV ? 32'(7) : 32'(5));
    chk("t2_o1", 32'(outw(1)), 32'(6));
    chk("t2_o2", 32'(outw(2)), REV ? 32'(5) : 32'(7));

    // Zero-length start is ignored
    start_frame(0);
    chk("t3_len0_busy", 32'(busy), 32'(0));
    tick();
    chk("t3_len0_done", 32'(done), 32'(0));

    // Oversized frame clamps to the RAM depth
    clear_logs();
    m_ready = 1'b1;
    start_frame(200);
    for (int i = 0; i < DEPTH; i++) push(100 + i, 1);
    wait_done(DEPTH + 10);
    tick();
    chk("t3_nwr", 32'(wr_q.size()), 32'(128));
    chk("t3_wr127", 32'(wrw(127)), 32'(127));
    chk("t3_nout", 32'(out_q.size()), 32'(128));
    chk("t3_o0", 32'(outw(0)), REV ? 32'(227) : 32'(100));
    chk("t3_last127", 32'(lastw(127)), 32'(1));
    nl = 0;
    foreach (last_q[k]) nl += last_q[k];
    chk("t3_nlast", 32'(nl), 32'(1));

    // Single-word frame
    clear_logs();
    start_frame(1);
    push(77, 1);
    wait_done(5);
    tick();
    chk("t3_one_o0", 32'(outw(0)), 32'(77));
    chk("t3_one_last", 32'(lastw(0)), 32'(1));

    // start during FILL ignored; start in the done cycle accepted
    clear_logs();
    start_frame(3);
    start = 1'b1; frame_len = 9'd5;
    push(31, 1);
    start = 1'b0;
    push(32, 1); push(33, 1);
    wait_done(10);
    start_frame(2);
    chk("t4_b2b_busy", 32'(busy), 32'(1));
    push(41, 1); push(42, 1);
    wait_done(10);
    tick();
    chk("t4_nout", 32'(out_q.size()), 32'(5));
    chk("t4_o0", 32'(outw(0)), REV ? 32'(33) : 32'(31));
    chk("t4_o2", 32'(outw(2)), REV ? 32'(31) : 32'(33));
    chk("t4_o3", 32'(outw(3)), REV ? 32'(42) : 32'(41));
    chk("t4_o4", 32'(outw(4)), REV ? 32'(41) : 32'(42));

    // Reset in the middle of replay
    clear_logs();
    start_frame(4);
    push(11, 1); push(12, 1); push(13, 1); push(14, 1);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_mvalid", 32'(m_valid), 32'(0));
    chk("t5_done", 32'(done), 32'(0));
    tick();
    chk("t5_done2", 32'(done), 32'(0));
    chk("t5_nout", 32'(out_q.size()), 32'(2));
    chk("t5_o0", 32'(outw(0)), REV ? 32'(14) : 32'(11));
    chk("t5_o1", 32'(outw(1)), REV ? 32'(13) : 32'(12));
    clear_logs();
    start_frame(2);
    push(21, 1); push(22, 1);
    wait_done(10);
    tick();
    chk("t5_new_o0", 32'(outw(0)), REV ? 32'(22) : 32'(21));
    chk("t5_new_o1", 32'(outw(1)), REV ? 32'(21) : 32'(22));
    chk("t5_new_last", 32'(lastw(1)), 32'(1));

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
